rr_arbiter8: RTL and testbench

//   Round-robin arbiter that shares one downstream resource among 8 requesters.
//   - Grant is one-hot; a 3-bit grant index is also provided.
//   - The winner keeps the grant until it drops its request, or until a hold-time limit forces a hand-over.
//   - Sits in front of any shared datapath that needs a single owner per cycle plus its binary index.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_arbiter8_if.sv | 10 +
 rtl/rr_pick8.sv | 22 ++
 rtl/rr_arbiter8.sv | 58 +++++
 tb/tb_rr_arbiter8.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter constants, FSM state type and one-hot to index helper
package arb_pkg;
  localparam int ARB_N = 8;
  localparam int ARB_IDX_W = 3;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [ARB_IDX_W-1:0] onehot8_to_idx(input logic [ARB_N-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_N; i++) idx = oh[i] ? idx | ARB_IDX_W'(i) : idx;
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: arbiter bus; master drives req, slave returns gnt, gnt_idx, gnt_valid, preempt
interface rr_arbiter8_if import arb_pkg::*; ();
  logic [ARB_N-1:0] req;
  logic [ARB_N-1:0] gnt;
  logic [ARB_IDX_W-1:0] gnt_idx;
  logic gnt_valid;
  logic preempt;
  modport master (output req, input gnt, gnt_idx, gnt_valid, preempt);
  modport slave (input req, output gnt, gnt_idx, gnt_valid, preempt);
endinterface

// File: rtl/rr_pick8.sv
// rr_pick8: round-robin pick; in req/ptr/excl, out win_oh/win_idx/any via rotate, lowest-bit, rotate back
module rr_pick8 import arb_pkg::*; (
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] ptr,
  input  logic [ARB_N-1:0]     excl,
  output logic [ARB_N-1:0]     win_oh,
  output logic [ARB_IDX_W-1:0] win_idx,
  output logic                 any
);
  logic [ARB_N-1:0] m, rot, first;
  logic [2*ARB_N-1:0] dbl_r, dbl_b;
  always_comb begin
    m = req & ~excl;
    dbl_r = {m, m} >> ptr;
    rot = dbl_r[ARB_N-1:0];
    first = rot & (~rot + 1'b1);
    dbl_b = {first, first} << ptr;
    win_oh = dbl_b[2*ARB_N-1:ARB_N];
    win_idx = onehot8_to_idx(first) + ptr;
    any = |m;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with hold limit; clk/rst plus slave bus (req in, registered gnt/gnt_idx/gnt_valid/preempt out)
module rr_arbiter8 import arb_pkg::*; #(
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter8_if.slave bus
);
  localparam int HC_W = $clog2(MAX_HOLD + 2);
  state_t state, state_n;
  logic [ARB_N-1:0] gnt, gnt_n, win_oh;
  logic [ARB_IDX_W-1:0] idx, idx_n, ptr, ptr_n, win_idx;
  logic valid, valid_n, pre, pre_n, any, own, at_lim, take;
  logic [HC_W-1:0] hc, hc_n;
  rr_pick8 u_pick (
    .req(bus.req),
    .ptr(ptr),
    .excl(gnt),
    .win_oh(win_oh),
    .win_idx(win_idx),
    .any(any)
  );
  always_comb begin
    own = |(bus.req & gnt);
    at_lim = (MAX_HOLD != 0) && (32'(hc) >= 32'(MAX_HOLD - 1));
    take = any && (state == IDLE || !own || at_lim);
    state_n = take ? GRANT : (own ? state : IDLE);
    gnt_n = take ? win_oh : (own ? gnt : '0);
    idx_n = take ? win_idx : (own ? idx : '0);
    valid_n = take || own;
    pre_n = take && own;
    ptr_n = take ? win_idx + 1'b1 : ptr;
    hc_n = (take || !own) ? '0 : (32'(hc) < 32'(MAX_HOLD)) ? hc + 1'b1 : hc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      idx <= '0;
      valid <= 1'b0;
      pre <= 1'b0;
      ptr <= '0;
      hc <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      idx <= idx_n;
      valid <= valid_n;
      pre <= pre_n;
      ptr <= ptr_n;
      hc <= hc_n;
    end
  end
  assign bus.gnt = gnt;
  assign bus.gnt_idx = idx;
  assign bus.gnt_valid = valid;
  assign bus.preempt = pre;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed and random checks of two arbiters (MAX_HOLD=4 and 0) against a behavioural model
module tb_rr_arbiter8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  bit live = 1'b0;
  rr_arbiter8_if ia ();
  rr_arbiter8_if ib ();
  rr_arbiter8 #(.MAX_HOLD(4)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  rr_arbiter8 #(.MAX_HOLD(0)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  always #5 clk = ~clk;
  int owner [2] = '{-1, -1};
  int ptr [2] = '{0, 0};
  int cnt [2] = '{0, 0};
  bit pre [2] = '{1'b0, 1'b0};
  int mh [2] = '{4, 0};
  logic [7:0] rq, oth;
  int o, p, c, w;
  bit pr;
  function automatic int pick(input logic [7:0] r, input int s);
    for (int j = 0; j < 8; j++) if (r[(s + j) % 8]) return (s + j) % 8;
    return -1;
  endfunction
  always @(posedge clk) begin
    live <= 1'b1;
    for (int u = 0; u < 2; u++) begin
      o = owner[u];
      p = ptr[u];
      c = cnt[u];
      pr = 1'b0;
      if (rst) begin
        o = -1;
        p = 0;
        c = 0;
      end else begin
        rq = ia.req;
        oth = rq;
        if (o >= 0) oth[o] = 1'b0;
        w = pick(oth, p);
        if (o >= 0 && rq[o] && !(mh[u] != 0 && c >= mh[u] && w >= 0)) c = c + 1;
        else if (w >= 0) begin
          pr = (o >= 0) && rq[o];
          o = w;
          p = (w + 1) % 8;
          c = 1;
        end else o = -1;
      end
      owner[u] <= o;
      ptr[u] <= p;
      cnt[u] <= c;
      pre[u] <= pr;
    end
  end
  always @(negedge clk) begin
    if (live) begin
      for (int u = 0; u < 2; u++) begin
        logic [7:0] g, eg;
        logic [2:0] gi, ei;
        logic gv, gp;
        g = u == 0 ? ia.gnt : ib.gnt;
        gi = u == 0 ? ia.gnt_idx : ib.gnt_idx;
        gv = u == 0 ? ia.gnt_valid : ib.gnt_valid;
        gp = u == 0 ? ia.preempt : ib.preempt;
        eg = owner[u] < 0 ? 8'h00 : 8'(1 << owner[u]);
        ei = owner[u] < 0 ? 3'd0 : 3'(owner[u]);
        checks++;
        if (g !== eg || gi !== ei || gv !== (owner[u] >= 0) || gp !== pre[u]) begin
          errors++;
          $display("FAIL model dut%0d t=%0t: got gnt=%h idx=%0d valid=%b pre=%b expected gnt=%h idx=%0d valid=%b pre=%b",
                   u, $time, g, gi, gv, gp, eg, ei, owner[u] >= 0, pre[u]);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic drive(input logic [7:0] r, input logic rs);
    ia.req = r;
    ib.req = r;
    rst = rs;
    @(negedge clk);
  endtask
  initial begin
    int seq [5] = '{2, 5, 7, 2, 5};
    logic [7:0] r;
    ia.req = 8'h00;
    ib.req = 8'h00;
    repeat (3) drive(8'hFF, 1'b1);
    chk("reset gnt", ia.gnt, 8'h00);
    chk("reset valid", {7'd0, ia.gnt_valid}, 8'h00);
    chk("reset idx", {5'd0, ia.gnt_idx}, 8'h00);
    drive(8'hFF, 1'b0);
    chk("first gnt", ia.gnt, 8'h01);
    chk("first idx", {5'd0, ia.gnt_idx}, 8'h00);
    drive(8'h00, 1'b1);
    drive(8'hA4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fair idx %0d", i), {5'd0, ia.gnt_idx}, 8'(seq[i]));
      drive(8'hA4, 1'b0);
      drive(8'hA4 & ~(8'h01 << seq[i]), 1'b0);
    end
    drive(8'h00, 1'b1);
    drive(8'h08, 1'b0);
    chk("handover owner3", ia.gnt, 8'h08);
    drive(8'h48, 1'b0);
    chk("handover hold", ia.gnt, 8'h08);
    drive(8'h40, 1'b0);
    chk("handover gnt", ia.gnt, 8'h40);
    chk("handover valid", {7'd0, ia.gnt_valid}, 8'h01);
    chk("handover preempt", {7'd0, ia.preempt}, 8'h00);
    drive(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(8'h03, 1'b0);
      chk($sformatf("hold0 cyc%0d", i), ia.gnt, 8'h01);
    end
    drive(8'h03, 1'b0);
    chk("preempt to 1 gnt", ia.gnt, 8'h02);
    chk("preempt to 1 pulse", {7'd0, ia.preempt}, 8'h01);
    drive(8'h03, 1'b0);
    chk("preempt one cycle", {7'd0, ia.preempt}, 8'h00);
    repeat (2) drive(8'h03, 1'b0);
    chk("hold1 last", ia.gnt, 8'h02);
    drive(8'h03, 1'b0);
    chk("preempt back to 0", ia.gnt, 8'h01);
    chk("preempt back pulse", {7'd0, ia.preempt}, 8'h01);
    chk("no-limit keeps 0", ib.gnt, 8'h01);
    drive(8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(8'h20, 1'b0);
      chk($sformatf("lone gnt %0d", i), ia.gnt, 8'h20);
      chk($sformatf("lone preempt %0d", i), {7'd0, ia.preempt}, 8'h00);
    end
    drive(8'h00, 1'b1);
    drive(8'h80, 1'b0);
    chk("wrap owner7", ia.gnt, 8'h80);
    drive(8'h03, 1'b0);
    chk("wrap next idx0", ia.gnt, 8'h01);
    drive(8'h03, 1'b1);
    chk("mid-grant reset", ia.gnt, 8'h00);
    drive(8'h03, 1'b0);
    chk("post-reset idx0", ia.gnt, 8'h01);
    r = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom) & 8'($urandom);
      drive(r, $urandom_range(99) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
